pool_window_ctrl: RTL and testbench

Parametrised control block for the streaming max-pool stage of the VGG16 accelerator. Tracks raster position of an incoming pixel stream (one pixel per valid_in beat) through a KxK window with stride S over an IMG_W x IMG_H frame. Flags each beat whose pixel completes a legal pooling window, and reports output coordinates and frame completion. Sits beside the line-buffer/comparator datapath and drives its output-valid and frame bookkeeping.

---
 rtl/pool_window_ctrl_pkg.sv | 7 +
 rtl/pool_window_ctrl_stride_counter.sv | 35 +++
 rtl/pool_window_ctrl.sv | 69 ++++++
 tb/tb_pool_window_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pool_window_ctrl_pkg.sv
// pool_pkg: shared state encoding and output-map sizing for the max-pool window controller
package pool_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  function automatic int out_dim(int img, int k, int s);
    return (img - k) / s + 1;
  endfunction
endpackage

// File: rtl/pool_window_ctrl_stride_counter.sv
// stride_counter: one pooling axis; position, stride phase and output index with window-hit flag
// ports: clk, rst (async high), clr (restart at 0), adv (step this axis), wrap (pos is last on axis)
//        pos/idx (current position and output index, clr folded in), hit (pos closes a legal window)
module stride_counter #(
  parameter int K  = 2,
  parameter int S  = 2,
  parameter int M  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic          wrap,
  output logic [CW-1:0] pos,
  output logic [CW-1:0] idx,
  output logic          hit
);
  logic [CW-1:0] pos_r, ph_r, idx_r, ph;
  // clr is folded in so a restart beat is evaluated as position 0 of a fresh frame
  assign pos = clr ? '0 : pos_r;
  assign ph  = clr ? '0 : ph_r;
  assign idx = clr ? '0 : idx_r;
  assign hit = pos >= CW'(K - 1) && ph == '0 && idx < CW'(M);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pos_r <= '0;
      ph_r  <= '0;
      idx_r <= '0;
    end else if (clr || adv) begin
      pos_r <= (!adv || wrap) ? '0 : pos + CW'(1);
      ph_r  <= (!adv || wrap || pos < CW'(K - 1) || ph == CW'(S - 1)) ? '0 : ph + CW'(1);
      idx_r <= (!adv || wrap) ? '0 : idx + CW'(hit);
    end
endmodule

// File: rtl/pool_window_ctrl.sv
// pool_window_ctrl: raster/window tracker for the streaming max-pool stage
// ports: clk, rst (async high), start (frame restart), valid_in (pixel beat)
//        valid_out/out_col/out_row (registered window-complete flag and output coords)
//        frame_done (pulse with the last window of a frame), busy (FILL or RUN)
module pool_window_ctrl
  import pool_pkg::*;
#(
  parameter int IMG_W = 112,
  parameter int IMG_H = 112,
  parameter int K     = 2,
  parameter int S     = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          valid_in,
  output logic          valid_out,
  output logic [CW-1:0] out_col,
  output logic [CW-1:0] out_row,
  output logic          frame_done,
  output logic          busy
);
  localparam int OW = out_dim(IMG_W, K, S);
  localparam int OH = out_dim(IMG_H, K, S);
  // with a 1-row window there is nothing to buffer, so frames enter RUN directly
  localparam state_t ENTRY = (K == 1) ? RUN : FILL;
  state_t state, st_c, ns;
  logic [CW-1:0] col, row, oc, orow;
  logic col_hit, row_hit, col_last, row_last, row_adv, hit, done_hit;
  assign col_last = col == CW'(IMG_W - 1);
  assign row_last = row == CW'(IMG_H - 1);
  assign row_adv  = valid_in && col_last;
  stride_counter #(.K(K), .S(S), .M(OW), .CW(CW)) u_col (
    .clk(clk), .rst(rst), .clr(start), .adv(valid_in), .wrap(col_last),
    .pos(col), .idx(oc), .hit(col_hit)
  );
  stride_counter #(.K(K), .S(S), .M(OH), .CW(CW)) u_row (
    .clk(clk), .rst(rst), .clr(start), .adv(row_adv), .wrap(row_last),
    .pos(row), .idx(orow), .hit(row_hit)
  );
  assign hit      = valid_in && col_hit && row_hit;
  assign done_hit = hit && oc == CW'(OW - 1) && orow == CW'(OH - 1);
  assign busy     = state == FILL || state == RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= ns;
  always_comb begin
    // DONE and restarts fall straight into a new frame; the current beat is part of it
    st_c = (start || state == DONE || (state == IDLE && valid_in)) ? ENTRY : state;
    ns   = st_c;
    if (valid_in && col_last && row_last) ns = DONE;
    else if (st_c == FILL && row_adv && row == CW'(K - 2)) ns = RUN;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      out_col    <= '0;
      out_row    <= '0;
    end else begin
      valid_out  <= hit;
      frame_done <= done_hit;
      if (hit || start) begin
        out_col <= oc;
        out_row <= orow;
      end
    end
endmodule

// File: tb/tb_pool_window_ctrl.sv
// tb_pool_window_ctrl: four geometries driven by one stream, scoreboard-checked against a div/mod raster model
module tb_pool_window_ctrl;
  localparam int ND = 4;
  localparam int PW[ND] = '{8, 7, 9, 4};
  localparam int PH[ND] = '{8, 7, 8, 4};
  localparam int PK[ND] = '{2, 3, 2, 1};
  localparam int PS[ND] = '{2, 2, 2, 1};

  typedef struct packed {
    logic [3:0]       vo, done, busy;
    logic [3:0][15:0] c, r;
  } exp_t;

  typedef struct packed {
    int              beats;
    bit              gaps;
    bit              start0;
    int              restart_at;
    int              rst_at;
    logic [3:0][7:0] evo;
    logic [3:0][7:0] edone;
  } phase_t;

  logic clk = 1'b0;
  logic rst, start, valid_in;
  logic [ND-1:0] vo, fd, bz;
  logic [15:0] oc [ND];
  logic [15:0] orw [ND];

  exp_t   sbq[$];
  phase_t ph[5];
  int pix[ND];
  bit started[ND];
  int cnt_vo[ND];
  int cnt_done[ND];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pool_window_ctrl #(.IMG_W(PW[g]), .IMG_H(PH[g]), .K(PK[g]), .S(PS[g]), .CW(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
      .valid_out(vo[g]), .out_col(oc[g]), .out_row(orw[g]),
      .frame_done(fd[g]), .busy(bz[g])
    );
  end

  function automatic int odim(int n, int k, int s);
    return (n - k) / s + 1;
  endfunction

  function automatic bit on_grid(int x, int k, int s);
    return x >= k - 1 && (x - k + 1) % s == 0;
  endfunction

  function automatic phase_t mk(int b, bit gp, bit s0, int ra, int rs,
                                int v0, int v1, int v2, int v3, int d0, int d1, int d2, int d3);
    phase_t p;
    p.beats = b;
    p.gaps = gp;
    p.start0 = s0;
    p.restart_at = ra;
    p.rst_at = rs;
    p.evo = {8'(v3), 8'(v2), 8'(v1), 8'(v0)};
    p.edone = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    return p;
  endfunction

  task automatic cmp(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", nm, g, $time, act, exp);
    end
  endtask

  task automatic check();
    exp_t e;
    if (sbq.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty @%0t: got 0 entries, expected 1", $time);
      return;
    end
    e = sbq.pop_front();
    for (int g = 0; g < ND; g++) begin
      cmp("valid_out", g, 32'(vo[g]), 32'(e.vo[g]));
      cmp("frame_done", g, 32'(fd[g]), 32'(e.done[g]));
      cmp("busy", g, 32'(bz[g]), 32'(e.busy[g]));
      if (e.vo[g]) begin
        cmp("out_col", g, 32'(oc[g]), 32'(e.c[g]));
        cmp("out_row", g, 32'(orw[g]), 32'(e.r[g]));
      end
      cnt_vo[g] += int'(vo[g]);
      cnt_done[g] += int'(fd[g]);
    end
  endtask

  task automatic step(input logic v, input logic s);
    exp_t e;
    e = '0;
    valid_in = v;
    start = s;
    for (int g = 0; g < ND; g++) begin
      int x, y;
      bit last;
      if (s) pix[g] = 0;
      if (v || s) started[g] = 1'b1;
      x = pix[g] % PW[g];
      y = pix[g] / PW[g];
      last = v && pix[g] == PW[g] * PH[g] - 1;
      e.vo[g] = v && on_grid(x, PK[g], PS[g]) && on_grid(y, PK[g], PS[g]);
      e.c[g] = 16'((x - PK[g] + 1) / PS[g]);
      e.r[g] = 16'((y - PK[g] + 1) / PS[g]);
      e.done[g] = e.vo[g] && int'(e.c[g]) == odim(PW[g], PK[g], PS[g]) - 1
                          && int'(e.r[g]) == odim(PH[g], PK[g], PS[g]) - 1;
      e.busy[g] = started[g] && !last;
      if (v) pix[g] = last ? 0 : pix[g] + 1;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    ph[0] = mk(64,  1'b0, 1'b0, -1, -1, 16,  9, 12,  64, 1, 1, 0, 4);
    ph[1] = mk(64,  1'b1, 1'b1, -1, -1, 16,  9, 12,  64, 1, 1, 0, 4);
    ph[2] = mk(128, 1'b0, 1'b1, -1, -1, 32, 21, 28, 128, 2, 2, 1, 8);
    ph[3] = mk(84,  1'b0, 1'b1, 20, -1, 20, 11, 16,  84, 1, 1, 0, 5);
    ph[4] = mk(85,  1'b0, 1'b1, 21, 20, 20, 11, 16,  84, 1, 1, 0, 5);
    rst = 1'b1;
    start = 1'b0;
    valid_in = 1'b0;
    for (int g = 0; g < ND; g++) begin
      pix[g] = 0;
      started[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < ND; g++) begin
      cmp("reset_valid_out", g, 32'(vo[g]), 0);
      cmp("reset_frame_done", g, 32'(fd[g]), 0);
      cmp("reset_busy", g, 32'(bz[g]), 0);
      cmp("reset_out_col", g, 32'(oc[g]), 0);
      cmp("reset_out_row", g, 32'(orw[g]), 0);
    end
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int g = 0; g < ND; g++) begin
        cnt_vo[g] = 0;
        cnt_done[g] = 0;
      end
      for (int b = 0; b < ph[p].beats; b++) begin
        if (b == ph[p].rst_at) begin
          valid_in = 1'b0;
          start = 1'b0;
          rst = 1'b1;
          #1;
          for (int g = 0; g < ND; g++) begin
            cmp("async_rst_valid_out", g, 32'(vo[g]), 0);
            cmp("async_rst_frame_done", g, 32'(fd[g]), 0);
            cmp("async_rst_busy", g, 32'(bz[g]), 0);
            cmp("async_rst_out_col", g, 32'(oc[g]), 0);
            cmp("async_rst_out_row", g, 32'(orw[g]), 0);
            pix[g] = 0;
            started[g] = 1'b0;
          end
          @(posedge clk);
          #1;
          rst = 1'b0;
        end else begin
          if (ph[p].gaps) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
          step(1'b1, (b == 0 && ph[p].start0) || b == ph[p].restart_at);
        end
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      for (int g = 0; g < ND; g++) begin
        cmp($sformatf("phase%0d_pulses", p), g, 32'(cnt_vo[g]), 32'(ph[p].evo[g]));
        cmp($sformatf("phase%0d_frame_done_pulses", p), g, 32'(cnt_done[g]), 32'(ph[p].edone[g]));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
